// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Brief    : Shared types and constants for the two-port line memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_HI        = 31;
    localparam int ADDR_LO        = 4;
    localparam int DEFAULT_LINE_W = 128;

    typedef logic [ADDR_HI:ADDR_LO] line_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    typedef logic req_id_t;
    localparam req_id_t REQ_I = 1'b0;
    localparam req_id_t REQ_D = 1'b1;

    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: mem_arbiter_if
// Brief    : I-side, D-side and memory-side signals of the line arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int CNT_W  = 16
) ();

    logic              read_I;
    logic              write_I;
    line_addr_t        addr_I;
    logic [LINE_W-1:0] wdata_I;
    logic [LINE_W-1:0] rdata_I;
    logic              ready_I;

    logic              read_D;
    logic              write_D;
    line_addr_t        addr_D;
    logic [LINE_W-1:0] wdata_D;
    logic [LINE_W-1:0] rdata_D;
    logic              ready_D;

    logic              mem_read;
    logic              mem_write;
    line_addr_t        mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    logic [CNT_W-1:0]  gnt_cnt_I;
    logic [CNT_W-1:0]  gnt_cnt_D;

    // Arbiter side
    modport slave (
        input  read_I, write_I, addr_I, wdata_I,
        input  read_D, write_D, addr_D, wdata_D,
        input  mem_rdata, mem_ready,
        output rdata_I, ready_I, rdata_D, ready_D,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output gnt_cnt_I, gnt_cnt_D
    );

    // Requester / memory / environment side
    modport master (
        output read_I, write_I, addr_I, wdata_I,
        output read_D, write_D, addr_D, wdata_D,
        output mem_rdata, mem_ready,
        input  rdata_I, ready_I, rdata_D, ready_D,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  gnt_cnt_I, gnt_cnt_D
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Combinational two-way round-robin picker with one-side exclusion.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_gnt,
    input  logic       excl_valid,
    input  req_id_t    excl_id,
    output logic       gnt_valid,
    output req_id_t    gnt_id
);

    logic [1:0] w_excl_mask;
    logic [1:0] w_elig;

    always_comb begin
        w_excl_mask = 2'b00;
        if (excl_valid) begin
            w_excl_mask[excl_id] = 1'b1;
        end
        w_elig    = req & ~w_excl_mask;
        gnt_valid = |w_elig;

        // A tie goes to whichever side did not win last time
        gnt_id = REQ_I;
        if (w_elig == 2'b11) begin
            gnt_id = other_id(last_gnt);
        end else if (w_elig[REQ_D]) begin
            gnt_id = REQ_D;
        end
    end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one line-wide slow memory between the I- and D-cache ports,
//            one transaction at a time, with a one-cycle gap between grants.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    arb_state_e        state_q,     state_d;
    req_id_t           owner_q,     owner_d;
    req_id_t           last_gnt_q,  last_gnt_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    line_addr_t        mem_addr_q,  mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cnt_i_q,     cnt_i_d;
    logic [CNT_W-1:0]  cnt_d_q,     cnt_d_d;

    logic [1:0]        w_req;
    logic              w_excl_valid;
    logic              w_gnt_valid;
    req_id_t           w_gnt_id;
    logic              w_win_write;
    line_addr_t        w_win_addr;
    logic [LINE_W-1:0] w_win_wdata;

    assign w_req        = {bus.read_D | bus.write_D, bus.read_I | bus.write_I};
    assign w_excl_valid = (state_q == GAP);

    mem_arb_pick u_pick (
        .req        (w_req),
        .last_gnt   (last_gnt_q),
        .excl_valid (w_excl_valid),
        .excl_id    (owner_q),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    // Command of whichever side the picker selects; write wins over read
    always_comb begin
        if (w_gnt_id == REQ_D) begin
            w_win_write = bus.write_D;
            w_win_addr  = bus.addr_D;
            w_win_wdata = bus.wdata_D;
        end else begin
            w_win_write = bus.write_I;
            w_win_addr  = bus.addr_I;
            w_win_wdata = bus.wdata_I;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_i_d     = cnt_i_q;
        cnt_d_d     = cnt_d_q;

        case (state_q)
            SERVE: begin
                if (bus.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = GAP;
                end
            end
            default: begin
                if (w_gnt_valid) begin
                    state_d     = SERVE;
                    owner_d     = w_gnt_id;
                    last_gnt_d  = w_gnt_id;
                    mem_write_d = w_win_write;
                    mem_read_d  = ~w_win_write;
                    mem_addr_d  = w_win_addr;
                    mem_wdata_d = w_win_wdata;
                    if (w_gnt_id == REQ_I) begin
                        if (cnt_i_q != c_cnt_max) begin
                            cnt_i_d = cnt_i_q + c_cnt_one;
                        end
                    end else begin
                        if (cnt_d_q != c_cnt_max) begin
                            cnt_d_d = cnt_d_q + c_cnt_one;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= REQ_I;
            last_gnt_q  <= REQ_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_i_q     <= '0;
            cnt_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_i_q     <= cnt_i_d;
            cnt_d_q     <= cnt_d_d;
        end
    end

    // Completion is passed straight through, but only to the current owner
    assign bus.ready_I   = (state_q == SERVE) && (owner_q == REQ_I) && bus.mem_ready;
    assign bus.ready_D   = (state_q == SERVE) && (owner_q == REQ_D) && bus.mem_ready;
    assign bus.rdata_I   = bus.mem_rdata;
    assign bus.rdata_D   = bus.mem_rdata;

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.gnt_cnt_I = cnt_i_q;
    assign bus.gnt_cnt_D = cnt_d_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LINE_W = 128;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.LINE_W(LINE_W), .CNT_W(CNT_W)) bus   ();
    mem_arbiter_if #(.LINE_W(LINE_W), .CNT_W(SAT_W)) bus_s ();

    mem_arbiter #(.LINE_W(LINE_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.LINE_W(LINE_W), .CNT_W(SAT_W)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int                mem_lat = 5;
    logic              stray   = 1'b0;
    int                busy_cnt;
    logic [LINE_W-1:0] cur_rdata;

    // Memory responder: mem_ready comes mem_lat cycles after the command appears
    initial begin
        busy_cnt      = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        cur_rdata     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_read || bus.mem_write) begin
                bus.mem_ready = (busy_cnt == mem_lat);
                busy_cnt++;
            end else begin
                busy_cnt      = 0;
                bus.mem_ready = 1'b0;
            end
            if (stray) bus.mem_ready = 1'b1;
            cur_rdata     = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.mem_rdata = cur_rdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.read_I  = 1'b0; bus.write_I = 1'b0; bus.addr_I = '0; bus.wdata_I = '0;
        bus.read_D  = 1'b0; bus.write_D = 1'b0; bus.addr_D = '0; bus.wdata_D = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        mem_lat = 5;
        stray   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(input bit side, input int max_cyc, output bit found, output int cyc);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (side ? bus.ready_D : bus.ready_I) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cmd: mem_read=%b mem_write=%b want 0 0", bus.mem_read, bus.mem_write);
        end
        n_cmp++;
        if (bus.mem_addr !== 28'h0 || bus.mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: mem_addr=%h mem_wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
        end
        n_cmp++;
        if (bus.ready_I !== 1'b0 || bus.ready_D !== 1'b0 || bus.gnt_cnt_I !== 16'd0 || bus.gnt_cnt_D !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_misc: ready_I=%b ready_D=%b cntI=%0d cntD=%0d want all 0",
                     bus.ready_I, bus.ready_D, bus.gnt_cnt_I, bus.gnt_cnt_D);
        end
    endtask

    task automatic test_single_read();
        bit found;
        int cyc;
        do_reset();
        bus.read_I = 1'b1;
        bus.addr_I = 28'h0000010;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: mem_read=%b want 0 in request cycle", bus.mem_read);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000010) begin
            n_fail++;
            $display("FAIL single_cmd: rd=%b wr=%b addr=%h want 1 0 0000010", bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        n_cmp++;
        if (bus.gnt_cnt_I !== 16'd1 || bus.gnt_cnt_D !== 16'd0) begin
            n_fail++;
            $display("FAIL single_cnt: cntI=%0d cntD=%0d want 1 0", bus.gnt_cnt_I, bus.gnt_cnt_D);
        end
        wait_ready(REQ_I, 30, found, cyc);
        n_cmp++;
        if (!found || cyc != mem_lat) begin
            n_fail++;
            $display("FAIL single_latency: found=%0d cycles=%0d want 1 %0d", found, cyc, mem_lat);
        end
        n_cmp++;
        if (bus.rdata_I !== cur_rdata || bus.ready_D !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rdata: rdata_I=%h ready_D=%b want %h 0", bus.rdata_I, bus.ready_D, cur_rdata);
        end
        step();
        bus.read_I = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_read !== 1'b0 || bus.ready_I !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: mem_read=%b ready_I=%b want 0 0", bus.mem_read, bus.ready_I);
        end
    endtask

    task automatic test_tie();
        bit found;
        int cyc;
        logic [LINE_W-1:0] a5;
        a5 = {16{8'hA5}};
        do_reset();
        bus.read_I  = 1'b1;
        bus.addr_I  = 28'h0000030;
        bus.write_D = 1'b1;
        bus.addr_D  = 28'h0000020;
        bus.wdata_D = a5;
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0000020 || bus.mem_wdata !== a5) begin
            n_fail++;
            $display("FAIL tie_first: wr=%b rd=%b addr=%h wdata=%h want D write to 0000020",
                     bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
        end
        wait_ready(REQ_D, 30, found, cyc);
        n_cmp++;
        if (!found || bus.ready_I !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_ready_D: found=%0d ready_I=%b want 1 0", found, bus.ready_I);
        end
        step();
        bus.write_D = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_gap: rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0000030 || bus.gnt_cnt_I !== 16'd1 || bus.gnt_cnt_D !== 16'd1) begin
            n_fail++;
            $display("FAIL tie_second: rd=%b addr=%h cntI=%0d cntD=%0d want 1 0000030 1 1",
                     bus.mem_read, bus.mem_addr, bus.gnt_cnt_I, bus.gnt_cnt_D);
        end
        wait_ready(REQ_I, 30, found, cyc);
        step();
        bus.read_I = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_id_t exp_id;
        req_id_t got;
        bit      found;
        int      cyc;
        do_reset();
        mem_lat     = 3;
        exp_id      = REQ_D;
        bus.read_I  = 1'b1;
        bus.addr_I  = 28'h0000100;
        bus.read_D  = 1'b1;
        bus.addr_D  = 28'h0000200;
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            cyc   = 0;
            while (!found && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (bus.ready_I || bus.ready_D) found = 1'b1;
            end
            n_cmp++;
            if (!found) begin
                n_fail++;
                $display("FAIL b2b_timeout: transaction %0d got no ready", k);
                break;
            end
            got = bus.ready_D ? REQ_D : REQ_I;
            n_cmp++;
            if (got !== exp_id || cyc != mem_lat + 2) begin
                n_fail++;
                $display("FAIL b2b_order: txn %0d side=%0d cycles=%0d want side=%0d cycles=%0d",
                         k, got, cyc, exp_id, mem_lat + 2);
            end
            n_cmp++;
            if (bus.mem_addr !== (got == REQ_D ? bus.addr_D : bus.addr_I)) begin
                n_fail++;
                $display("FAIL b2b_addr: txn %0d mem_addr=%h want %h", k, bus.mem_addr,
                         (got == REQ_D ? bus.addr_D : bus.addr_I));
            end
            exp_id = ~exp_id;
            step();
            if (got == REQ_D) bus.addr_D = bus.addr_D + 28'h1;
            else              bus.addr_I = bus.addr_I + 28'h1;
        end
        @(negedge clk);
        n_cmp++;
        if (bus.gnt_cnt_I !== 16'd3 || bus.gnt_cnt_D !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_cnt: cntI=%0d cntD=%0d want 3 3", bus.gnt_cnt_I, bus.gnt_cnt_D);
        end
    endtask

    task automatic test_addr_change();
        bit found;
        do_reset();
        mem_lat    = 4;
        bus.read_D = 1'b1;
        bus.addr_D = 28'h0000040;
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.mem_addr !== 28'h0000040 || bus.mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_start: addr=%h rd=%b want 0000040 1", bus.mem_addr, bus.mem_read);
        end
        step();
        bus.addr_D  = 28'h0000050;
        bus.wdata_D = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.write_D = 1'b1;
        bus.read_I  = 1'b1;
        bus.addr_I  = 28'h0000070;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.mem_addr !== 28'h0000040 || bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.ready_I !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_serve: cycle %0d addr=%h rd=%b wr=%b ready_I=%b want 0000040 1 0 0",
                         c, bus.mem_addr, bus.mem_read, bus.mem_write, bus.ready_I);
            end
            if (bus.ready_D) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL hold_ready: ready_D not seen, want 1");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat     = 20;
        bus.write_I = 1'b1;
        bus.addr_I  = 28'h0000060;
        bus.wdata_I = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: mem_write=%b want 1 before reset edge", bus.mem_write);
        end
        stray = 1'b1;
        step();
        rst         = 1'b0;
        bus.write_I = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0 || bus.mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_bus: rd=%b wr=%b addr=%h wdata=%h want all 0",
                     bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        n_cmp++;
        if (bus.ready_I !== 1'b0 || bus.ready_D !== 1'b0 || bus.gnt_cnt_I !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_ready: ready_I=%b ready_D=%b cntI=%0d with stray mem_ready want 0 0 0",
                     bus.ready_I, bus.ready_D, bus.gnt_cnt_I);
        end
        stray = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.ready_I !== 1'b0 || bus.mem_write !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_after: cycle %0d ready_I=%b mem_write=%b want 0 0", c, bus.ready_I, bus.mem_write);
            end
        end
    endtask

    // Random traffic against a transaction-level model of the sharing rules
    task automatic test_random();
        bit                act   [2];
        bit                rd    [2];
        bit                wr    [2];
        line_addr_t        addr  [2];
        logic [LINE_W-1:0] wd    [2];
        bit                saw   [2];
        logic [CNT_W-1:0]  m_cnt [2];
        bit                busy, cool;
        req_id_t           owner, last, cool_id, win;
        bit                e_wr;
        line_addr_t        e_addr;
        logic [LINE_W-1:0] e_wd;
        logic [1:0]        elig;
        int                op;
        int                grants;

        do_reset();
        busy = 0; cool = 0; owner = REQ_I; last = REQ_I; cool_id = REQ_I;
        e_wr = 0; e_addr = '0; e_wd = '0; grants = 0;
        for (int s = 0; s < 2; s++) begin
            act[s] = 0; rd[s] = 0; wr[s] = 0; addr[s] = '0; wd[s] = '0; saw[s] = 0; m_cnt[s] = '0;
        end

        for (int cycle = 0; cycle < 400; cycle++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                if ((saw[s] && $urandom_range(0, 1) == 0) || (!act[s] && !saw[s] && $urandom_range(0, 3) == 0)) begin
                    op      = int'($urandom_range(0, 2));
                    act[s]  = 1;
                    rd[s]   = (op != 1);
                    wr[s]   = (op != 0);
                    addr[s] = 28'($urandom());
                    wd[s]   = {$urandom(), $urandom(), $urandom(), $urandom()};
                end else if (saw[s]) begin
                    act[s] = 0; rd[s] = 0; wr[s] = 0;
                end
                if (!act[s]) begin
                    addr[s] = 28'($urandom());
                    wd[s]   = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
            end
            bus.read_I = rd[0]; bus.write_I = wr[0]; bus.addr_I = addr[0]; bus.wdata_I = wd[0];
            bus.read_D = rd[1]; bus.write_D = wr[1]; bus.addr_D = addr[1]; bus.wdata_D = wd[1];

            @(negedge clk);
            n_cmp++;
            if (busy ? (bus.mem_write !== e_wr || bus.mem_read !== !e_wr || bus.mem_addr !== e_addr || bus.mem_wdata !== e_wd)
                     : (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0)) begin
                n_fail++;
                $display("FAIL random_cmd: cycle %0d rd=%b wr=%b addr=%h busy=%0d want wr=%b addr=%h",
                         cycle, bus.mem_read, bus.mem_write, bus.mem_addr, busy, e_wr, e_addr);
            end
            n_cmp++;
            if (bus.ready_I !== (busy && owner == REQ_I && bus.mem_ready) ||
                bus.ready_D !== (busy && owner == REQ_D && bus.mem_ready) ||
                bus.rdata_I !== cur_rdata || bus.rdata_D !== cur_rdata) begin
                n_fail++;
                $display("FAIL random_ready: cycle %0d ready_I=%b ready_D=%b want %b %b",
                         cycle, bus.ready_I, bus.ready_D,
                         busy && owner == REQ_I && bus.mem_ready, busy && owner == REQ_D && bus.mem_ready);
            end
            n_cmp++;
            if (bus.gnt_cnt_I !== m_cnt[0] || bus.gnt_cnt_D !== m_cnt[1]) begin
                n_fail++;
                $display("FAIL random_cnt: cycle %0d cntI=%0d cntD=%0d want %0d %0d",
                         cycle, bus.gnt_cnt_I, bus.gnt_cnt_D, m_cnt[0], m_cnt[1]);
            end

            saw[0] = busy && owner == REQ_I && bus.mem_ready;
            saw[1] = busy && owner == REQ_D && bus.mem_ready;

            if (busy) begin
                if (bus.mem_ready) begin
                    busy = 0; cool = 1; cool_id = owner;
                end
            end else begin
                elig = {rd[1] | wr[1], rd[0] | wr[0]};
                if (cool) elig[cool_id] = 1'b0;
                cool = 0;
                if (elig != 2'b00) begin
                    win   = (elig == 2'b11) ? ~last : elig[1];
                    busy  = 1; owner = win; last = win; grants++;
                    if (m_cnt[win] != 16'hFFFF) m_cnt[win] += 16'd1;
                    e_wr   = wr[win];
                    e_addr = addr[win];
                    e_wd   = wd[win];
                end
            end

            if (saw[0] || saw[1]) mem_lat = int'($urandom_range(0, 3));
            stray = ($urandom_range(0, 9) == 0);
        end
        stray = 1'b0;
        n_cmp++;
        if (grants < 20) begin
            n_fail++;
            $display("FAIL random_activity: grants=%0d want at least 20", grants);
        end
    endtask

    task automatic test_saturate();
        int n;
        logic [SAT_W-1:0] exp_cnt;
        do_reset();
        n = 0;
        bus_s.read_I    = 1'b1;
        bus_s.addr_I    = 28'h0000010;
        bus_s.mem_ready = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (bus_s.ready_I) begin
                n++;
                exp_cnt = (n > 7) ? 3'd7 : 3'(n);
                n_cmp++;
                if (bus_s.gnt_cnt_I !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL sat_cnt: grant %0d cntI=%0d want %0d", n, bus_s.gnt_cnt_I, exp_cnt);
                end
            end
        end
        n_cmp++;
        if (n < 10 || bus_s.gnt_cnt_D !== 3'd0) begin
            n_fail++;
            $display("FAIL sat_total: grants=%0d cntD=%0d want >=10 0", n, bus_s.gnt_cnt_D);
        end
        bus_s.read_I    = 1'b0;
        bus_s.mem_ready = 1'b0;
    endtask

    initial begin
        bus_s.read_I = 1'b0; bus_s.write_I = 1'b0; bus_s.addr_I = '0; bus_s.wdata_I = '0;
        bus_s.read_D = 1'b0; bus_s.write_D = 1'b0; bus_s.addr_D = '0; bus_s.wdata_D = '0;
        bus_s.mem_ready = 1'b0; bus_s.mem_rdata = '0;

        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_addr_change();
        test_reset_mid();
        test_random();
        test_saturate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single `slow_memory` instance between the I-cache and D-cache miss/write-back ports of `CHIP`. It lets a board-level configuration with one backing memory replace the separate `slow_memI`/`slow_memD` pair. The block sequences one 128-bit line transaction at a time: it latches the winning command, drives the memory, and routes `mem_ready`/`mem_rdata` back to the owner. It sits between `CHIP` and `slow_memory`.

## Interface
- `LINE_W`, 128, line data width
- `CNT_W`, 16, width of saturating per-requester grant counters
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `read_I`, `write_I`  in  1  I-side command (level, held until `ready_I`)
- `addr_I`  in  [31:4]  I-side line address
- `wdata_I`  in  LINE_W  I-side write data
- `rdata_I`  out  LINE_W  read data to I-side (valid when `ready_I`)
- `ready_I`  out  1  one-cycle completion pulse to I-side
- `read_D`, `write_D`, `addr_D`, `wdata_D`, `rdata_D`, `ready_D`: same widths and meaning, D-side
- `mem_read`, `mem_write`  out  1  to `slow_memory`, registered
- `mem_addr`  out  [31:4]  registered
- `mem_wdata`  out  LINE_W  registered
- `mem_rdata`  in  LINE_W  from memory
- `mem_ready`  in  1  memory completion
- `gnt_cnt_I`, `gnt_cnt_D`  out  CNT_W  grants issued per side, saturating

## Operation
- Request from side X: `read_X | write_X`. When both are set, the request is treated as a write; `mem_read` stays 0.
- FSM states: IDLE, SERVE, GAP. The reset state is IDLE.
- IDLE/GAP to SERVE: taken on the edge where at least one eligible request exists.
  - Winner: the only requester, or on a tie the side not in `last_gnt`.
  - On that edge, latch the winner's addr, wdata and write flag into `mem_addr`/`mem_wdata`/`mem_write`/`mem_read`.
  - Set `owner` and `last_gnt` to the winner, and increment that side's `gnt_cnt` (holds at all-ones).
- SERVE: memory outputs are held constant; requester input changes are ignored.
  - `ready_owner = mem_ready` (combinational); the other ready is 0.
  - On the edge after `mem_ready`=1: clear `mem_read`/`mem_write` and go to GAP.
- GAP: exactly one cycle with `mem_read`=`mem_write`=0.
  - The just-served side is not eligible.
  - The other side may win, giving SERVE on the next edge.
  - With no eligible request, go to IDLE.
- IDLE: an idle requester's inputs have no effect on memory outputs.
- `rdata_I` and `rdata_D` are both driven from `mem_rdata` at all times. The value is meaningful only with the respective ready.
- `ready_X` is never asserted outside SERVE, nor for the non-owner. `mem_ready` seen in IDLE/GAP is ignored.

## Timing
- Reset values: state IDLE; `mem_read`, `mem_write` 0; `mem_addr` 0; `mem_wdata` 0; `ready_I`, `ready_D` 0; `last_gnt` = I, so D wins the first tie; both `gnt_cnt` 0.
- Arbitration latency: a request first high in cycle t gives `mem_*` valid in cycle t+1.
- Completion: `ready_X` is high in the same cycle as `mem_ready`, for exactly that cycle. Memory outputs drop one edge later.
- Minimum spacing between two transactions is one GAP cycle.
- Back-to-back alternation I/D/I/D with both sides requesting continuously: each transaction takes memory latency + 2 cycles.
- Requester rules:
  - Hold command, addr and wdata until its ready.
  - Deassert by the cycle after ready; the GAP exclusion covers that cycle.
- Reset mid-transaction: on the reset edge all outputs return to reset values and the in-flight transaction is abandoned. No ready is issued afterwards.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `{IDLE, SERVE, GAP}`
  - requester ID type/constants `REQ_I`=0, `REQ_D`=1
  - `ADDR_HI`=31, `ADDR_LO`=4
  - default `LINE_W`
- Sub-module `mem_arb_pick`: combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `last_gnt`, `excl_valid`, `excl_id`.
  - Outputs: `gnt_valid`, `gnt_id`.
- All registers live in `mem_arbiter`.

## Test plan
- Reset, then `read_I` at `addr_I`=0x0000010 with memory latency 5 -> `mem_read`=1 and `mem_addr`=0x0000010 one cycle after request. `ready_I` pulses with `mem_ready`, `rdata_I`=`mem_rdata`. `ready_D` stays 0 and `gnt_cnt_I`=1.
- `read_I` and `write_D` (`addr_D`=0x0000020, `wdata_D`=128'hA5…A5) asserted in the same cycle after reset -> D granted first with `mem_write`=1 and `mem_wdata`=A5…A5. GAP cycle follows with `mem_read`=`mem_write`=0, then I is granted.
- Both sides hold requests continuously for 6 transactions -> grant order D,I,D,I,D,I. Each counter reads 3.
- D changes `addr_D` mid-SERVE -> `mem_addr` unchanged until `ready_D`.
- Assert `rst` two cycles into SERVE with a stray `mem_ready` pulse in the following cycle -> all outputs 0 on the reset edge and no ready pulse.
- Force 65540 I grants -> `gnt_cnt_I` saturates at 0xFFFF.
